spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_master_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: command/address/data frame sequencer with per-frame chip select.
// Optional macro SPI_CS_HOLD_EN stretches CS_HOLD to 2*CLK_DIV cycles (default: 1 cycle).
module spi_master_ctrl #(
    parameter int unsigned          CMD_W   = 8,
    parameter int unsigned          ADDR_W  = 16,
    parameter int unsigned          DATA_W  = 32,
    parameter int unsigned          NUM_CS  = 4,
    parameter int unsigned          CLK_DIV = 4,
    parameter logic [CMD_W-1:0]     RD_CMD  = CMD_W'(8'h0F),
    localparam int unsigned         CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic              spi_run,
    input  logic [CMD_W-1:0]  spi_com,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [DATA_W-1:0] mosi_data,
    input  logic [CS_W-1:0]   cs_sel,
    output logic              busy,
    output logic              spi_done,
    output logic [DATA_W-1:0] miso_data,
    output logic              sclk,
    output logic [NUM_CS-1:0] cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int unsigned TOT_W = CMD_W + ADDR_W + DATA_W;
`ifdef SPI_CS_HOLD_EN
    localparam int unsigned HOLD_CYC = 2 * CLK_DIV;
`else
    localparam int unsigned HOLD_CYC = 1;
`endif
    localparam int unsigned CNT_W = $clog2(2 * CLK_DIV + 1);
    localparam int unsigned BIT_W = $clog2(TOT_W + 1);

    typedef enum logic [2:0] {
        StIdle,
        StCsSetup,
        StCmd,
        StAddr,
        StDataTx,
        StDataRx,
        StCsHold
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_div_cnt;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic               r_sclk;
    logic [TOT_W-1:0]   r_tx_sr;
    logic [DATA_W-1:0]  r_rx_sr;
    logic [DATA_W-1:0]  r_miso_data;
    logic [CS_W-1:0]    r_cs_sel;
    logic               r_rd;
    logic               r_done;
    logic               w_div_end;
    logic               w_hold_end;
    logic               w_bit_end;

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_div_end    = (r_div_cnt == CNT_W'(CLK_DIV - 1));
        w_hold_end   = (r_div_cnt == CNT_W'(HOLD_CYC - 1));
        // A bit ends when the high half-period of sclk expires.
        w_bit_end    = w_div_end && r_sclk;
        unique case (r_state)
            StIdle: begin
                if (spi_run) w_state_next = StCsSetup;
            end
            StCsSetup: begin
                if (w_div_end) w_state_next = StCmd;
            end
            StCmd: begin
                if (w_bit_end && r_bit_cnt == BIT_W'(CMD_W - 1)) w_state_next = StAddr;
            end
            StAddr: begin
                if (w_bit_end && r_bit_cnt == BIT_W'(CMD_W + ADDR_W - 1)) begin
                    w_state_next = r_rd ? StDataRx : StDataTx;
                end
            end
            StDataTx, StDataRx: begin
                if (w_bit_end && r_bit_cnt == BIT_W'(TOT_W - 1)) w_state_next = StCsHold;
            end
            StCsHold: begin
                if (w_hold_end) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_div_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_sclk      <= 1'b0;
            r_tx_sr     <= '0;
            r_rx_sr     <= '0;
            r_miso_data <= '0;
            r_cs_sel    <= '0;
            r_rd        <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_div_cnt <= '0;
                    r_bit_cnt <= '0;
                    r_sclk    <= 1'b0;
                    if (spi_run) begin
                        r_tx_sr  <= {spi_com, spi_addr, mosi_data};
                        r_cs_sel <= cs_sel;
                        r_rd     <= (spi_com == RD_CMD);
                    end
                end
                StCsSetup: begin
                    r_div_cnt <= w_div_end ? '0 : r_div_cnt + CNT_W'(1);
                end
                StCmd, StAddr, StDataTx, StDataRx: begin
                    if (w_div_end) begin
                        r_div_cnt <= '0;
                        r_sclk    <= ~r_sclk;
                        if (!r_sclk && r_state == StDataRx) begin
                            r_rx_sr <= {r_rx_sr[DATA_W-2:0], miso};
                        end
                        if (r_sclk) begin
                            r_tx_sr   <= {r_tx_sr[TOT_W-2:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                            // All DATA_W samples are in by the last falling edge.
                            if (r_state == StDataRx && r_bit_cnt == BIT_W'(TOT_W - 1)) begin
                                r_miso_data <= r_rx_sr;
                            end
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + CNT_W'(1);
                    end
                end
                StCsHold: begin
                    if (w_hold_end) begin
                        r_div_cnt <= '0;
                        r_done    <= 1'b1;
                    end else begin
                        r_div_cnt <= r_div_cnt + CNT_W'(1);
                    end
                end
                default: r_div_cnt <= '0;
            endcase
        end
    end

    always_comb begin
        mosi = 1'b1;
        if (r_state == StCsSetup || r_state == StCmd || r_state == StAddr ||
            r_state == StDataTx) begin
            mosi = r_tx_sr[TOT_W-1];
        end
    end

    // Out-of-range selects match no index, so every cs_n stays high.
    always_comb begin
        cs_n = '1;
        if (r_state != StIdle) begin
            for (int i = 0; i < NUM_CS; i++) begin
                if (r_cs_sel == CS_W'(i)) cs_n[i] = 1'b0;
            end
        end
    end

    assign busy      = (r_state != StIdle);
    assign spi_done  = r_done;
    assign miso_data = r_miso_data;
    assign sclk      = r_sclk;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: frames are queued at launch and checked at spi_done.
`timescale 1ns/1ps
module tb_spi_master_ctrl;

    localparam int CMD_W   = 8;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int NUM_CS  = 5;
    localparam int CLK_DIV = 4;
    localparam int CS_W    = 3;
    localparam int TOT_W   = CMD_W + ADDR_W + DATA_W;
`ifdef SPI_CS_HOLD_EN
    localparam int HOLD = 2 * CLK_DIV;
`else
    localparam int HOLD = 1;
`endif
    localparam int FRAME_LEN = CLK_DIV * (1 + 2 * TOT_W) + HOLD;

    logic              mclk = 1'b0;
    logic              rst = 1'b1;
    logic              spi_run = 1'b0;
    logic [CMD_W-1:0]  spi_com = '0;
    logic [ADDR_W-1:0] spi_addr = '0;
    logic [DATA_W-1:0] mosi_data = '0;
    logic [CS_W-1:0]   cs_sel = '0;
    logic              busy;
    logic              spi_done;
    logic [DATA_W-1:0] miso_data;
    logic              sclk;
    logic [NUM_CS-1:0] cs_n;
    logic              mosi;
    logic              miso;

    spi_master_ctrl #(
        .CMD_W  (CMD_W),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NUM_CS (NUM_CS),
        .CLK_DIV(CLK_DIV),
        .RD_CMD (8'h0F)
    ) u_dut (
        .mclk     (mclk),
        .rst      (rst),
        .spi_run  (spi_run),
        .spi_com  (spi_com),
        .spi_addr (spi_addr),
        .mosi_data(mosi_data),
        .cs_sel   (cs_sel),
        .busy     (busy),
        .spi_done (spi_done),
        .miso_data(miso_data),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic [TOT_W-1:0]  bits;
        logic [NUM_CS-1:0] cs_mask;
        logic [DATA_W-1:0] miso;
        int                len;
    } exp_t;

    exp_t              sb_q[$];
    logic [DATA_W-1:0] model_miso = '0;
    logic [DATA_W-1:0] slave_resp = '0;
    int                n_checks = 0;
    int                n_errors = 0;
    int                done_cnt = 0;

    // Monitor accumulators for the frame in flight
    int                rises = 0;
    int                cs_low = 0;
    logic [TOT_W-1:0]  mosi_cap = '0;
    logic [NUM_CS-1:0] cs_and = '1;
    logic              multi_low = 1'b0;
    logic              mosi_bad = 1'b0;
    logic              prev_sclk = 1'b0;
    logic              prev_mosi = 1'b1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave: presents response bit for the upcoming rise while sclk is low.
    always_comb begin
        miso = 1'b0;
        if (rises >= 24 && rises < 56) miso = slave_resp[5'(55 - rises)];
    end

    task automatic clear_mon();
        rises     = 0;
        cs_low    = 0;
        mosi_cap  = '0;
        cs_and    = '1;
        multi_low = 1'b0;
        mosi_bad  = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge mclk);
            if (rst) begin
                clear_mon();
                prev_sclk = 1'b0;
                prev_mosi = 1'b1;
            end else begin
                if (sclk && !prev_sclk) begin
                    rises++;
                    mosi_cap = {mosi_cap[TOT_W-2:0], mosi};
                end
                if (sclk && prev_sclk && mosi !== prev_mosi) mosi_bad = 1'b1;
                if (cs_n != '1) cs_low++;
                cs_and = cs_and & cs_n;
                if ($countones(~cs_n) > 1) multi_low = 1'b1;
                if (spi_done) begin
                    done_cnt++;
                    check("sb_nonempty", 64'(sb_q.size() != 0), 64'(1));
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("sclk_rises", 64'(rises), 64'(TOT_W));
                        check("mosi_bits", 64'(mosi_cap), 64'(e.bits));
                        check("cs_mask", 64'(cs_and), 64'(e.cs_mask));
                        check("cs_low_len", 64'(cs_low), 64'(e.len));
                        check("miso_data", 64'(miso_data), 64'(e.miso));
                        check("busy_at_done", 64'(busy), 64'(0));
                        check("cs_high_at_done", 64'(cs_n), 64'(5'h1F));
                        check("one_cs_low", 64'(multi_low), 64'(0));
                        check("mosi_stable_hi", 64'(mosi_bad), 64'(0));
                    end
                    clear_mon();
                end
                prev_sclk = sclk;
                prev_mosi = mosi;
            end
        end
    end

    task automatic tick();
        @(negedge mclk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] com, input logic [15:0] addr,
                            input logic [31:0] data, input logic [2:0] cs,
                            input logic [31:0] resp);
        exp_t e;
        if (com == 8'h0F) begin
            e.bits     = {com, addr, 32'hFFFF_FFFF};
            model_miso = resp;
        end else begin
            e.bits = {com, addr, data};
        end
        e.miso    = model_miso;
        e.cs_mask = (int'(cs) < NUM_CS) ? ~(5'b1 << cs) : 5'h1F;
        e.len     = (int'(cs) < NUM_CS) ? FRAME_LEN : 0;
        sb_q.push_back(e);
    endtask

    task automatic start(input logic [7:0] com, input logic [15:0] addr,
                         input logic [31:0] data, input logic [2:0] cs,
                         input logic [31:0] resp);
        int t;
        t = 0;
        while (busy && t < 2000) begin
            tick();
            t++;
        end
        check("idle_before_start", 64'(busy), 64'(0));
        spi_com    = com;
        spi_addr   = addr;
        mosi_data  = data;
        cs_sel     = cs;
        slave_resp = resp;
        spi_run    = 1'b1;
        push_exp(com, addr, data, cs, resp);
        tick();
        spi_run = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (done_cnt < target && t < 3000) begin
            tick();
            t++;
        end
        check("done_count", 64'(done_cnt), 64'(target));
    endtask

    initial begin
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_cs_n", 64'(cs_n), 64'(5'h1F));
        check("rst_mosi", 64'(mosi), 64'(1));
        check("rst_sclk", 64'(sclk), 64'(0));
        check("rst_miso_data", 64'(miso_data), 64'(0));
        rst = 1'b0;
        repeat (5) tick();
        check("idle_no_start", 64'(busy), 64'(0));

        start(8'h01, 16'h1234, 32'hDEAD_BEEF, 3'd2, 32'h0);
        wait_done(1);
        start(8'h0F, 16'h0040, 32'h0, 3'd1, 32'hA5A5_0FF0);
        wait_done(2);
        start(8'h02, 16'hABCD, 32'h1234_5678, 3'd4, 32'h0);
        wait_done(3);

        // spi_run pulse mid-frame must be ignored
        start(8'h01, 16'h5555, 32'hCAFE_F00D, 3'd0, 32'h0);
        repeat (100) tick();
        spi_com   = 8'h0F;
        mosi_data = 32'h0;
        spi_run   = 1'b1;
        tick();
        spi_run = 1'b0;
        check("busy_mid_frame", 64'(busy), 64'(1));
        wait_done(4);
        repeat (20) tick();
        check("single_done", 64'(done_cnt), 64'(4));
        check("idle_after_ignore", 64'(busy), 64'(0));

        // Reset after 20 sclk rises aborts the frame
        start(8'h0F, 16'h0040, 32'h0, 3'd3, 32'h1234_5678);
        begin
            int t;
            t = 0;
            while (rises < 20 && t < 2000) begin
                tick();
                t++;
            end
        end
        check("rises_before_rst", 64'(rises), 64'(20));
        rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_done", 64'(spi_done), 64'(0));
        check("arst_cs_n", 64'(cs_n), 64'(5'h1F));
        check("arst_sclk", 64'(sclk), 64'(0));
        check("arst_mosi", 64'(mosi), 64'(1));
        check("arst_miso_data", 64'(miso_data), 64'(0));
        void'(sb_q.pop_back());
        model_miso = '0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (50) tick();
        check("no_start_after_rst", 64'(busy), 64'(0));
        check("no_done_on_abort", 64'(done_cnt), 64'(4));
        start(8'h0F, 16'h0040, 32'h0, 3'd3, 32'hA5A5_0FF0);
        wait_done(5);

        // Back-to-back: spi_run held for three frames
        spi_com   = 8'h01;
        spi_addr  = 16'h0F0F;
        mosi_data = 32'h1357_9BDF;
        cs_sel    = 3'd1;
        for (int k = 0; k < 3; k++) push_exp(8'h01, 16'h0F0F, 32'h1357_9BDF, 3'd1, 32'h0);
        spi_run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int t;
            t = 0;
            do begin
                tick();
                t++;
            end while (!spi_done && t < 2000);
            check("b2b_done_pulse", 64'(spi_done), 64'(1));
        end
        spi_run = 1'b0;
        repeat (20) tick();
        check("b2b_done_count", 64'(done_cnt), 64'(8));
        check("b2b_idle", 64'(busy), 64'(0));

        // Out-of-range chip select
        start(8'h01, 16'h0000, 32'hFFFF_0000, 3'd5, 32'h0);
        wait_done(9);
        check("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
